mental_sum_game: RTL

Parametrised successor to the single-player mental-arithmetic game core. Presents `N_TERMS` pseudo-random operands of `TERM_W` bits one at a time on a two-digit BCD display. It then waits for the player's answer, with a timeout, and scores it. Sits between the board I/O (switches, buttons, LEDs, 7-segment drivers) and the top level. Replaces the fixed 5-term, fixed-schedule game, adding start/submit handshakes, an answer timeout and round counting.

---
 rtl/mental_sum_game.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mental_sum_game.sv
// Mental-arithmetic game core: shows N_TERMS pseudo-random operands on a
// two-digit display, waits (with timeout) for the player's sum, scores it.
module mental_sum_game #(
  parameter int N_TERMS       = 5,
  parameter int TERM_W        = 5,
  parameter int SHOW_CYCLES   = 10,
  parameter int ANSWER_CYCLES = 40,
  parameter int RESULT_CYCLES = 10,
  parameter int SCORE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               submit,
  input  logic [7:0]         seed,
  input  logic [7:0]         answer,
  output logic [7:0]         disp_val,
  output logic [3:0]         bcd_tens,
  output logic [3:0]         bcd_units,
  output logic [1:0]         phase,
  output logic [2:0]         term_idx,
  output logic               correct,
  output logic               timed_out,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] rounds
);

  localparam int ACC_W   = TERM_W + 3;
  localparam int MAX_SR  = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
  localparam int MAX_CYC = (MAX_SR > ANSWER_CYCLES) ? MAX_SR : ANSWER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    ANSWER = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [7:0]         lfsr, lfsr_n, lfsr_step;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         idx_n;
  logic [7:0]         disp_n;
  logic               correct_n, timed_out_n;
  logic [SCORE_W-1:0] score_n, rounds_n;
  logic [TERM_W-1:0]  term;
  logic [7:0]         target, score_mod, term_mod;

  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign term      = lfsr[TERM_W-1:0];
  assign target    = 8'(32'(acc) % 32'd100);
  assign score_mod = 8'(32'(score) % 32'd100);
  // Operands wider than 6 bits can exceed 99; the display shows them mod 100
  // so disp_val always stays a valid two-digit value.
  assign term_mod  = 8'(32'(term) % 32'd100);
  assign phase     = state;

  // BCD digits are derived combinationally from the registered display value
  always_comb begin
    bcd_tens  = 4'(disp_val / 8'd10);
    bcd_units = 4'(disp_val % 8'd10);
  end

  // Next-state and next-output logic for the round sequencer
  always_comb begin
    state_n     = state;
    lfsr_n      = lfsr;
    acc_n       = acc;
    cnt_n       = cnt;
    idx_n       = term_idx;
    disp_n      = disp_val;
    correct_n   = correct;
    timed_out_n = timed_out;
    score_n     = score;
    rounds_n    = rounds;
    case (state)
      IDLE: begin
        disp_n = score_mod;
        if (start) begin
          state_n = SHOW;
          acc_n   = ACC_W'(term);
          lfsr_n  = lfsr_step;
          idx_n   = '0;
          cnt_n   = CNT_W'(SHOW_CYCLES);
          disp_n  = term_mod;
        end
      end
      SHOW: begin
        if (cnt == CNT_W'(1)) begin
          if (term_idx < 3'(N_TERMS - 1)) begin
            acc_n  = acc + ACC_W'(term);
            lfsr_n = lfsr_step;
            idx_n  = term_idx + 3'd1;
            cnt_n  = CNT_W'(SHOW_CYCLES);
            disp_n = term_mod;
          end else begin
            state_n = ANSWER;
            cnt_n   = CNT_W'(ANSWER_CYCLES);
            disp_n  = '0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ANSWER: begin
        // submit takes priority over expiry on the same cycle
        if (submit || (cnt == CNT_W'(1))) begin
          state_n     = RESULT;
          cnt_n       = CNT_W'(RESULT_CYCLES);
          disp_n      = target;
          correct_n   = submit && (answer == target);
          timed_out_n = !submit;
          if (rounds != '1) rounds_n = rounds + SCORE_W'(1);
          if (correct_n && (score != '1)) score_n = score + SCORE_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESULT: begin
        if (cnt == CNT_W'(1)) begin
          state_n     = IDLE;
          correct_n   = 1'b0;
          timed_out_n = 1'b0;
          disp_n      = score_mod;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any round and reloads the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= (seed == 8'h00) ? 8'h01 : seed;
      acc       <= '0;
      cnt       <= '0;
      term_idx  <= '0;
      disp_val  <= '0;
      correct   <= 1'b0;
      timed_out <= 1'b0;
      score     <= '0;
      rounds    <= '0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      term_idx  <= idx_n;
      disp_val  <= disp_n;
      correct   <= correct_n;
      timed_out <= timed_out_n;
      score     <= score_n;
      rounds    <= rounds_n;
    end
  end

endmodule
